uart_receiver: RTL and testbench

//   UART RX: deserialises an asynchronous 8N1-style line (start, DATA_BITS LSB-first, 1 stop)

---
 rtl/uart_receiver.sv | 122 ++++++++++++
 tb/tb_uart_receiver.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start/data/stop framing on a shared baud Tick,
// mid-bit sampling, false-start rejection and framing-error reporting.
module uart_receiver #(
  parameter int DATA_BITS      = 8,
  parameter int OVERSAMPLE     = 16,
  parameter int STOP_BIT_TICKS = 16
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 Tick,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] DataOut,
  output logic                 RxDone,
  output logic                 FrameError
);

  // The tick counter must reach both a full bit period and the stop-bit span.
  localparam int TICK_SPAN = (STOP_BIT_TICKS > OVERSAMPLE) ? STOP_BIT_TICKS : OVERSAMPLE;
  localparam int TW        = (TICK_SPAN > 1) ? $clog2(TICK_SPAN) : 1;
  localparam int BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BIT_TICKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q;
  logic [TW-1:0]        tickCnt_q;
  logic [BW-1:0]        bitCnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 rxMeta_q;
  logic                 rxSync_q;

  // Rx is asynchronous; reset to the idle-high level so no false start follows reset.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= Rx;
      rxSync_q <= rxMeta_q;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= IDLE;
      tickCnt_q  <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      DataOut    <= '0;
      RxDone     <= 1'b0;
      FrameError <= 1'b0;
    end else begin
      RxDone <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rxSync_q) begin
            state_q   <= START;
            tickCnt_q <= '0;
          end
        end
        START: begin
          if (Tick) begin
            if (tickCnt_q == HALF_LAST) begin
              tickCnt_q <= '0;
              if (!rxSync_q) begin
                state_q  <= DATA;
                bitCnt_q <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              tickCnt_q <= tickCnt_q + TW'(1);
            end
          end
        end
        DATA: begin
          if (Tick) begin
            if (tickCnt_q == BIT_LAST) begin
              tickCnt_q <= '0;
              shift_q   <= {rxSync_q, shift_q[DATA_BITS-1:1]};
              if (bitCnt_q == DATA_LAST) begin
                state_q <= STOP;
              end else begin
                bitCnt_q <= bitCnt_q + BW'(1);
              end
            end else begin
              tickCnt_q <= tickCnt_q + TW'(1);
            end
          end
        end
        // Leaving at mid stop bit lets a following start edge be caught with no idle gap.
        STOP: begin
          if (Tick) begin
            if (tickCnt_q == STOP_LAST) begin
              DataOut    <= shift_q;
              FrameError <= ~rxSync_q;
              RxDone     <= 1'b1;
              state_q    <= IDLE;
              tickCnt_q  <= '0;
            end else begin
              tickCnt_q <= tickCnt_q + TW'(1);
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          tickCnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are driven on Rx, expected bytes
// are queued at send time and compared whenever RxDone pulses.
module tb_uart_receiver;

  localparam int BIT_CLKS = 384;
  localparam int TICK_DIV = 24;

  logic       Clock  = 1'b0;
  logic       ResetN = 1'b0;
  logic       Tick   = 1'b0;
  logic       Rx     = 1'b1;
  logic [7:0] DataOut;
  logic       RxDone;
  logic       FrameError;

  typedef struct packed {
    logic [7:0] data;
    logic       frameErr;
  } exp_t;

  exp_t expQ[$];
  int   passCount   = 0;
  int   failCount   = 0;
  int   rxDoneCount = 0;

  uart_receiver #(
    .DATA_BITS(8),
    .OVERSAMPLE(16),
    .STOP_BIT_TICKS(16)
  ) dut (
    .Clock(Clock),
    .ResetN(ResetN),
    .Tick(Tick),
    .Rx(Rx),
    .DataOut(DataOut),
    .RxDone(RxDone),
    .FrameError(FrameError)
  );

  always #10 Clock = ~Clock;

  initial begin : tickGen
    forever begin
      repeat (TICK_DIV - 1) @(negedge Clock);
      Tick = 1'b1;
      @(negedge Clock);
      Tick = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic holdRx(input logic level, input int clocks);
    Rx = level;
    repeat (clocks) @(negedge Clock);
  endtask

  // Free-running serial frame; a bad stop bit is held low only just past mid-bit
  // so the receiver sees a false start afterwards rather than a break.
  task automatic applyStimulus(input logic [7:0] data, input logic goodStop);
    expQ.push_back({data, ~goodStop});
    holdRx(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) holdRx(data[i], BIT_CLKS);
    if (goodStop) begin
      holdRx(1'b1, BIT_CLKS);
    end else begin
      holdRx(1'b0, 240);
      holdRx(1'b1, BIT_CLKS - 240);
    end
  endtask

  task automatic waitTicks(input int n);
    repeat (n) begin
      @(posedge Clock);
      while (Tick !== 1'b1) @(posedge Clock);
    end
    @(negedge Clock);
  endtask

  // Behaves like a transmitter sharing the Tick: each bit lasts exactly 16 Ticks.
  task automatic applyLoopback(input logic [7:0] data);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    expQ.push_back({data, 1'b0});
    for (int i = 0; i < 10; i++) begin
      Rx = frame[i];
      waitTicks(16);
    end
  endtask

  task automatic waitDrain(input string tag);
    int budget;
    budget = 20 * BIT_CLKS;
    while (expQ.size() != 0 && budget > 0) begin
      @(negedge Clock);
      budget--;
    end
    checkOutput(tag, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      if (RxDone === 1'b1) begin
        rxDoneCount++;
        if (expQ.size() == 0) begin
          checkOutput("spurious RxDone", 32'(RxDone), 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("DataOut", 32'(DataOut), 32'(e.data));
          checkOutput("FrameError", 32'(FrameError), 32'(e.frameErr));
        end
        @(negedge Clock);
        checkOutput("RxDone one cycle", 32'(RxDone), 32'd0);
      end
    end
  end

  initial begin : stimulus
    Rx     = 1'b1;
    ResetN = 1'b0;
    repeat (5) @(negedge Clock);
    checkOutput("reset DataOut", 32'(DataOut), 32'd0);
    checkOutput("reset FrameError", 32'(FrameError), 32'd0);
    checkOutput("reset RxDone", 32'(RxDone), 32'd0);
    ResetN = 1'b1;
    repeat (BIT_CLKS) @(negedge Clock);
    checkOutput("idle DataOut", 32'(DataOut), 32'd0);
    checkOutput("idle RxDone count", 32'(rxDoneCount), 32'd0);

    $display("[TB] single frame 0xAA");
    applyStimulus(8'hAA, 1'b1);
    waitDrain("t1 drain");
    checkOutput("t1 RxDone count", 32'(rxDoneCount), 32'd1);

    $display("[TB] back-to-back 0x55, 0xFF");
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    waitDrain("t2 drain");
    checkOutput("t2 RxDone count", 32'(rxDoneCount), 32'd3);

    $display("[TB] start glitch then 0x3C");
    holdRx(1'b0, 4 * TICK_DIV);
    holdRx(1'b1, 2 * BIT_CLKS);
    checkOutput("t3 glitch RxDone count", 32'(rxDoneCount), 32'd3);
    checkOutput("t3 glitch DataOut held", 32'(DataOut), 32'hFF);
    applyStimulus(8'h3C, 1'b1);
    waitDrain("t3 drain");
    checkOutput("t3 RxDone count", 32'(rxDoneCount), 32'd4);

    $display("[TB] framing error 0x81 then 0x12");
    applyStimulus(8'h81, 1'b0);
    holdRx(1'b1, 2 * BIT_CLKS);
    checkOutput("t4 FrameError held", 32'(FrameError), 32'd1);
    checkOutput("t4 RxDone count bad", 32'(rxDoneCount), 32'd5);
    applyStimulus(8'h12, 1'b1);
    waitDrain("t4 drain");
    checkOutput("t4 FrameError cleared", 32'(FrameError), 32'd0);
    checkOutput("t4 RxDone count", 32'(rxDoneCount), 32'd6);

    $display("[TB] reset during data bit 4, then 0xC3");
    holdRx(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) holdRx(i[0], BIT_CLKS);
    holdRx(1'b1, BIT_CLKS / 2);
    ResetN = 1'b0;
    Rx     = 1'b1;
    repeat (3) @(negedge Clock);
    checkOutput("t5 reset DataOut", 32'(DataOut), 32'd0);
    checkOutput("t5 reset FrameError", 32'(FrameError), 32'd0);
    ResetN = 1'b1;
    holdRx(1'b1, 2 * BIT_CLKS);
    checkOutput("t5 aborted RxDone count", 32'(rxDoneCount), 32'd6);
    checkOutput("t5 DataOut after abort", 32'(DataOut), 32'd0);
    applyStimulus(8'hC3, 1'b1);
    waitDrain("t5 drain");
    checkOutput("t5 RxDone count", 32'(rxDoneCount), 32'd7);

    $display("[TB] tick-locked loopback 0x00, 0xFF, 0xA5");
    waitTicks(1);
    applyLoopback(8'h00);
    applyLoopback(8'hFF);
    applyLoopback(8'hA5);
    Rx = 1'b1;
    waitDrain("t6 drain");
    checkOutput("t6 RxDone count", 32'(rxDoneCount), 32'd10);
    checkOutput("t6 final DataOut", 32'(DataOut), 32'hA5);

    $display("%0d/%0d checks passed", passCount, passCount + failCount);
    $finish;
  end

endmodule
